fetch_prefetch_queue: RTL

//  Parametrised instruction fetch unit: owns the PC, issues word reads to instruction

---
 rtl/fetch_prefetch_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction fetch unit. Holds the PC and issues one word read at a time to
// instruction memory over a req/ack handshake. Returned words go into a
// DEPTH-entry prefetch FIFO that feeds decode over valid/ready. A taken
// branch flushes the FIFO and redirects the PC. If a read is still in flight
// when the branch arrives, its response is discarded.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   imem_req / imem_addr     read request and its address (held until ack)
//   imem_ack / imem_data     read response
//   br_valid/br_pc/br_imm    taken branch: target = br_pc + 4 + sext(imm)<<2
//   inst_valid/inst/inst_pc  FIFO head presented to decode
//   inst_ready               decode accepts the head
//   stat_fetch / stat_flush  fetch and flush counters; present only when
//                            FETCH_STATS_EN is defined
//
// Optional feature macro: FETCH_STATS_EN
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter int          IMM_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0040_0020
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [IMM_W-1:0]  br_imm,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetch,
    output logic [31:0]       stat_flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,   // no request outstanding
        ST_REQ,    // request outstanding; its response will be pushed
        ST_DRAIN   // request outstanding; its response will be dropped
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;        // next address to fetch
    logic [ADDR_W-1:0]  addr_q, addr_d;    // address of the outstanding request
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];

    logic [ADDR_W-1:0]  imm_ext;
    logic [ADDR_W-1:0]  br_target;
    logic               ack_live;
    logic               push;
    logic               pop;

    // Outputs come straight from registers. The head is forced to zero while
    // the FIFO is empty, so the unreset storage never reaches decode.
    assign imem_req   = (state_q != ST_IDLE);
    assign imem_addr  = addr_q;
    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : '0;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        imm_ext   = {{(ADDR_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
        br_target = br_pc + ADDR_W'(4) + (imm_ext << 2);

        // An ack counts only while a request is actually outstanding.
        ack_live = imem_ack && (state_q != ST_IDLE);
        push     = ack_live && (state_q == ST_REQ) && !br_valid;
        // A flush wins over a same-cycle pop.
        pop      = inst_valid && inst_ready && !br_valid;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (br_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        pc_d = pc_q;
        if (push)     pc_d = pc_q + ADDR_W'(4);
        if (br_valid) pc_d = br_target;

        // Only one request is ever in flight. A request is issued only when
        // the FIFO will have a free slot for its response.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_d < CNT_W'(DEPTH)) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_live)      state_d = (count_d < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
                else if (br_valid) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The stale response is dropped. Then fetch resumes at the
                // newest target. The FIFO is empty after the flush.
                if (ack_live) state_d = (count_d < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The request address follows pc whenever the next state is REQ.
        // While a request is still waiting for its ack, pc equals that
        // address, so the address stays held. In DRAIN, the old address is held.
        addr_d = addr_q;
        if (state_d == ST_REQ) addr_d = pc_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= ADDR_W'(RESET_PC);
            addr_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]   <= addr_q;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetch <= '0;
            stat_flush <= '0;
        end else begin
            if (push)     stat_fetch <= stat_fetch + 32'd1;
            if (br_valid) stat_flush <= stat_flush + 32'd1;
        end
    end
`endif

endmodule
